// File: rtl/window_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// window_ctrl_pkg
// Shared definitions for the windowed up/down count controller.
//   - Default parameter values for the count width, window length and
//     window counter width.
//   - State enumeration used by window_count_ctrl.
// ---------------------------------------------------------------------------
package window_ctrl_pkg;

  // 18 magnitude bits plus sign for the external up/down counter.
  localparam int DEF_WIDTH  = 19;
  // 1 s of samples at 200 kHz.
  localparam int DEF_WINDOW = 200000;
  // 2^18 = 262144 >= 200000.
  localparam int DEF_WIN_W  = 18;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CAPT  = 3'd4,
    ST_HOLD  = 3'd5
  } state_e;

endpackage

// File: rtl/sample_window_timer.sv
// ---------------------------------------------------------------------------
// sample_window_timer
// Counts accepted samples within one window and flags the last one.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-low reset (count -> 0)
//   clr    in   synchronous clear of the count
//   inc    in   advance the count by one
//   count  out  WIN_W  current number of samples accepted so far
//   last   out  1      high while count == WINDOW-1, i.e. the next accepted
//                      sample is the final one of the window
// ---------------------------------------------------------------------------
module sample_window_timer
  import window_ctrl_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int WIN_W  = DEF_WIN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIN_W-1:0] count,
  output logic             last
);

  localparam logic [WIN_W-1:0] LAST_CNT = WIN_W'(WINDOW - 1);

  logic [WIN_W-1:0] count_d;
  logic [WIN_W-1:0] count_q;

  // The count saturates at WINDOW-1 so it can never wrap, even when
  // WINDOW == 2^WIN_W; the controller leaves RUN on that same accept.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !last) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last  = (count_q == LAST_CNT);
  assign count = count_q;

endmodule

// File: rtl/window_count_ctrl.sv
// ---------------------------------------------------------------------------
// window_count_ctrl
// Runs an external up/down counter over a fixed window of WINDOW accepted
// samples and captures the signed result for a ready/valid consumer.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-low reset
//   start      in   begin a window (honoured only in IDLE)
//   abort      in   cancel the current window from any state
//   cont       in   continuous mode, sampled when a result is consumed
//   in_valid   in   sample strobe (cannot be stalled)
//   in_bit     in   sample polarity: 1 = count up, 0 = count down
//   cnt_val    in   WIDTH  current value of the external counter
//   cnt_up     out  registered up drive to the external counter
//   cnt_down   out  registered down drive to the external counter
//   cnt_rst_n  out  active-low synchronous clear to the external counter
//   res_data   out  WIDTH  captured window result (two's complement)
//   res_valid  out  result valid
//   res_ready  in   result consumed when high together with res_valid
//   busy       out  high in every state except IDLE
//   ovr        out  sticky: a sample arrived while busy but not in RUN
// ---------------------------------------------------------------------------
module window_count_ctrl
  import window_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int WINDOW = DEF_WINDOW,
  parameter int WIN_W  = DEF_WIN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             cnt_up,
  output logic             cnt_down,
  output logic             cnt_rst_n,
  output logic [WIDTH-1:0] res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             ovr
);

  state_e           state_d, state_q;
  logic             cnt_up_d, cnt_up_q;
  logic             cnt_down_d, cnt_down_q;
  logic [WIDTH-1:0] res_data_d, res_data_q;
  logic             res_valid_d, res_valid_q;
  logic             ovr_d, ovr_q;

  logic             win_clr;
  logic             win_inc;
  logic             win_last;
  logic [WIN_W-1:0] win_count;

  sample_window_timer #(
    .WINDOW (WINDOW),
    .WIN_W  (WIN_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (win_clr),
    .inc    (win_inc),
    .count  (win_count),
    .last   (win_last)
  );

  // Next-state logic. The up/down drives default to 0 so they are only ever
  // high for one cycle following an accepted sample in RUN, and can never be
  // high together. Abort overrides every transition below it.
  always_comb begin
    state_d     = state_q;
    cnt_up_d    = 1'b0;
    cnt_down_d  = 1'b0;
    res_data_d  = res_data_q;
    res_valid_d = res_valid_q;
    ovr_d       = ovr_q;
    win_clr     = 1'b0;
    win_inc     = 1'b0;

    // The sample stream cannot be stalled, so anything arriving while we are
    // busy but not counting is lost; remember that it happened.
    if (in_valid && (state_q != ST_IDLE) && (state_q != ST_RUN)) begin
      ovr_d = 1'b1;
    end

    if (abort) begin
      state_d     = ST_IDLE;
      res_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_CLEAR;
            ovr_d   = 1'b0;
            win_clr = 1'b1;
          end
        end
        // Also reached directly from HOLD in continuous mode, so the window
        // counter is cleared here as well as on start.
        ST_CLEAR: begin
          win_clr = 1'b1;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (in_valid) begin
            cnt_up_d   = in_bit;
            cnt_down_d = ~in_bit;
            win_inc    = 1'b1;
            if (win_last) begin
              state_d = ST_DRAIN;
            end
          end
        end
        // One cycle for the external counter to absorb the final registered
        // up/down drive before its value is captured.
        ST_DRAIN: begin
          state_d = ST_CAPT;
        end
        ST_CAPT: begin
          state_d     = ST_HOLD;
          res_data_d  = cnt_val;
          res_valid_d = 1'b1;
        end
        ST_HOLD: begin
          if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
            state_d     = cont ? ST_CLEAR : ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_up_q    <= 1'b0;
      cnt_down_q  <= 1'b0;
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_up_q    <= cnt_up_d;
      cnt_down_q  <= cnt_down_d;
      res_data_q  <= res_data_d;
      res_valid_q <= res_valid_d;
      ovr_q       <= ovr_d;
    end
  end

  // Combinational so the external counter clears on the same edge as our
  // own reset, and during the single CLEAR cycle.
  assign cnt_rst_n = reset & (state_q != ST_CLEAR);

  assign cnt_up    = cnt_up_q;
  assign cnt_down  = cnt_down_q;
  assign res_data  = res_data_q;
  assign res_valid = res_valid_q;
  assign ovr       = ovr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_window_count_ctrl.sv
// ---------------------------------------------------------------------------
// tb_window_count_ctrl
// Bench for window_count_ctrl with WINDOW = 8, WIDTH = 19. An external
// up/down counter sits alongside the DUT. Whole-window cases come from a
// vector table; abort, stall, continuous mode, start-while-busy and reset
// during HOLD are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_window_count_ctrl;

  localparam int WIDTH  = 19;
  localparam int WINDOW = 8;
  localparam int WIN_W  = 3;

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic             cont;
  logic             in_valid;
  logic             in_bit;
  logic [WIDTH-1:0] cnt_val;
  logic             cnt_up;
  logic             cnt_down;
  logic             cnt_rst_n;
  logic [WIDTH-1:0] res_data;
  logic             res_valid;
  logic             res_ready;
  logic             busy;
  logic             ovr;

  logic [WIDTH-1:0] ext_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0]       bits;
    int               gaps;
    logic [WIDTH-1:0] exp;
    string            tag;
  } vec_t;

  vec_t vecs [5];

  window_count_ctrl #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW),
    .WIN_W  (WIN_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .cont      (cont),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .cnt_val   (cnt_val),
    .cnt_up    (cnt_up),
    .cnt_down  (cnt_down),
    .cnt_rst_n (cnt_rst_n),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .ovr       (ovr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External up/down counter the controller drives.
  always_ff @(posedge clk) begin
    if (!cnt_rst_n) begin
      ext_cnt <= '0;
    end else if (cnt_up) begin
      ext_cnt <= ext_cnt + 1'b1;
    end else if (cnt_down) begin
      ext_cnt <= ext_cnt - 1'b1;
    end
  end

  assign cnt_val = ext_cnt;

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
    $fatal(1, "[TB] timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic c,
                               input logic v, input logic b, input logic r);
    start     = s;
    abort     = a;
    cont      = c;
    in_valid  = v;
    in_bit    = b;
    res_ready = r;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Start pulse from IDLE; leaves the DUT in RUN.
  task automatic begin_window(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput($sformatf("%s_clear_rst_n", tag), 32'(cnt_rst_n), 32'd0);
    checkOutput($sformatf("%s_clear_busy", tag), 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput($sformatf("%s_run_rst_n", tag), 32'(cnt_rst_n), 32'd1);
  endtask

  // Feed 8 samples, bits[0] first, with optional idle cycles between them
  // (never after the last one, so result latency stays measurable).
  task automatic feed(input logic [7:0] bits, input int gaps);
    for (int i = 0; i < WINDOW; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, bits[i], 1'b0);
      step();
      if (gaps > 0 && i < WINDOW - 1) begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (gaps) step();
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Called just after the edge that accepted the last sample.
  task automatic expect_result(input logic [WIDTH-1:0] exp, input string tag);
    checkOutput($sformatf("%s_valid_e0", tag), 32'(res_valid), 32'd0);
    step();
    checkOutput($sformatf("%s_valid_e1", tag), 32'(res_valid), 32'd0);
    checkOutput($sformatf("%s_drive_e1", tag), 32'(cnt_up | cnt_down), 32'd0);
    step();
    checkOutput($sformatf("%s_valid_e2", tag), 32'(res_valid), 32'd1);
    checkOutput($sformatf("%s_data", tag), 32'(res_data), 32'(exp));
  endtask

  task automatic consume(input logic c, input string tag);
    applyStimulus(1'b0, 1'b0, c, 1'b0, 1'b0, 1'b1);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput($sformatf("%s_consumed", tag), 32'(res_valid), 32'd0);
  endtask

  initial begin
    logic stable;

    vecs[0] = '{bits: 8'hFF, gaps: 0, exp: 19'd8,       tag: "ones"};
    vecs[1] = '{bits: 8'h1F, gaps: 0, exp: 19'd2,       tag: "five_three"};
    vecs[2] = '{bits: 8'h00, gaps: 0, exp: 19'h7FFF8,   tag: "zeros"};
    vecs[3] = '{bits: 8'hAA, gaps: 1, exp: 19'd0,       tag: "alt_gaps"};
    vecs[4] = '{bits: 8'h01, gaps: 2, exp: 19'h7FFFA,   tag: "one_up"};

    // Reset state.
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    checkOutput("rst_cnt_up", 32'(cnt_up), 32'd0);
    checkOutput("rst_cnt_down", 32'(cnt_down), 32'd0);
    checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
    checkOutput("rst_res_data", 32'(res_data), 32'd0);
    checkOutput("rst_ovr", 32'(ovr), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cnt_rst_n", 32'(cnt_rst_n), 32'd0);
    reset = 1'b1;
    step();
    checkOutput("idle_cnt_rst_n", 32'(cnt_rst_n), 32'd1);

    // Whole windows from the table.
    for (int k = 0; k < 5; k++) begin
      begin_window(vecs[k].tag);
      feed(vecs[k].bits, vecs[k].gaps);
      expect_result(vecs[k].exp, vecs[k].tag);
      consume(1'b0, vecs[k].tag);
      checkOutput($sformatf("%s_idle_busy", vecs[k].tag), 32'(busy), 32'd0);
      checkOutput($sformatf("%s_ovr", vecs[k].tag), 32'(ovr), 32'd0);
    end

    // Result held while res_ready is low; samples meanwhile set ovr.
    begin_window("stall");
    feed(8'hFF, 0);
    expect_result(19'd8, "stall");
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'(c % 2), 1'b1, 1'b0);
      step();
      if (res_valid !== 1'b1 || res_data !== 19'd8 || (cnt_up | cnt_down) !== 1'b0) begin
        stable = 1'b0;
      end
    end
    checkOutput("stall_stable", 32'(stable), 32'd1);
    checkOutput("stall_ovr", 32'(ovr), 32'd1);
    checkOutput("stall_busy", 32'(busy), 32'd1);
    consume(1'b0, "stall");
    checkOutput("stall_ovr_sticky", 32'(ovr), 32'd1);

    // Continuous mode: consume with cont=1 goes straight to one CLEAR cycle.
    begin_window("cont1");
    checkOutput("cont1_ovr_cleared", 32'(ovr), 32'd0);
    feed(8'hFF, 0);
    expect_result(19'd8, "cont1");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("cont_valid_low", 32'(res_valid), 32'd0);
    checkOutput("cont_clear_rst_n", 32'(cnt_rst_n), 32'd0);
    checkOutput("cont_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("cont_run_rst_n", 32'(cnt_rst_n), 32'd1);
    feed(8'h00, 0);
    expect_result(19'h7FFF8, "cont2");
    consume(1'b0, "cont2");
    checkOutput("cont2_idle_busy", 32'(busy), 32'd0);

    // Abort after 3 samples, then a full clean window.
    begin_window("abort");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_drive", 32'(cnt_up | cnt_down), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    stable = 1'b1;
    repeat (4) begin
      step();
      if (res_valid !== 1'b0 || busy !== 1'b0) stable = 1'b0;
    end
    checkOutput("abort_quiet", 32'(stable), 32'd1);
    begin_window("after_abort");
    feed(8'hFF, 0);
    expect_result(19'd8, "after_abort");
    consume(1'b0, "after_abort");

    // Start pulse in the middle of RUN must not restart the window.
    begin_window("midstart");
    for (int i = 0; i < WINDOW; i++) begin
      applyStimulus(1'(i == 3), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      step();
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_result(19'd8, "midstart");
    consume(1'b0, "midstart");

    // Reset while holding a result (with ovr set).
    begin_window("hold_rst");
    feed(8'hFF, 0);
    expect_result(19'd8, "hold_rst");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkOutput("hold_rst_ovr_pre", 32'(ovr), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    step();
    checkOutput("hold_rst_valid", 32'(res_valid), 32'd0);
    checkOutput("hold_rst_data", 32'(res_data), 32'd0);
    checkOutput("hold_rst_ovr", 32'(ovr), 32'd0);
    checkOutput("hold_rst_busy", 32'(busy), 32'd0);
    checkOutput("hold_rst_drive", 32'(cnt_up | cnt_down), 32'd0);
    checkOutput("hold_rst_cnt_rst_n", 32'(cnt_rst_n), 32'd0);
    reset = 1'b1;
    step();
    checkOutput("post_rst_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/window_count_ctrl.md
WINDOW_COUNT_CTRL -- requirements
Module: window_count_ctrl

Interface
REQ-001 Parameter: WIDTH, default 19, width of the up/down count value (18 magnitude bits plus sign).
REQ-002 Parameter: WINDOW, default 200000, number of accepted samples per window (1 s at 200 kHz).
REQ-003 Parameter: WIN_W, default 18, width of the internal window counter; SHALL satisfy 2^WIN_W >= WINDOW.
REQ-004 Port: clk  in  1  clock; all state changes on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-low reset.
REQ-006 Port: start  in  1  begin a window; honoured only in IDLE.
REQ-007 Port: abort  in  1  cancel the current window from any state.
REQ-008 Port: cont  in  1  continuous mode; sampled when a result is consumed.
REQ-009 Port: in_valid  in  1  sample strobe; this stream cannot be stalled.
REQ-010 Port: in_bit  in  1  sample polarity: 1 = count up, 0 = count down.
REQ-011 Port: cnt_val  in  WIDTH  current value of the external up/down counter.
REQ-012 Port: cnt_up, cnt_down  out  1 each  registered drive to the counter's up and down inputs.
REQ-013 Port: cnt_rst_n  out  1  active-low synchronous clear to the counter.
REQ-014 Port: res_data  out  WIDTH  captured window result (two's complement).
REQ-015 Port: res_valid / res_ready  out / in  1 each  result handshake.
REQ-016 Port: busy  out  1  high in every state except IDLE.
REQ-017 Port: ovr  out  1  sticky flag for samples dropped outside RUN.

Function
REQ-018 States: IDLE, CLEAR, RUN, DRAIN, CAPT, HOLD.
REQ-019 IDLE: start -> CLEAR; on that edge, ovr is cleared and the window counter is zeroed.
REQ-020 CLEAR: lasts exactly one cycle; cnt_rst_n = 0 for that cycle; then -> RUN.
REQ-021 cnt_rst_n SHALL be combinational: reset AND (state != CLEAR).
REQ-022 RUN, edge with in_valid=1: cnt_up <= in_bit, cnt_down <= !in_bit, and the window counter increments.
REQ-023 RUN, edge with in_valid=0: cnt_up <= 0 and cnt_down <= 0.
REQ-024 In every state other than RUN, cnt_up and cnt_down SHALL be 0; the two SHALL never be high together.
REQ-025 Accepting the WINDOW-th sample -> DRAIN; DRAIN -> CAPT unconditionally.
REQ-026 CAPT -> HOLD: on that edge, res_data <= cnt_val and res_valid <= 1.
REQ-027 Latency: res_valid rises on the 2nd edge after the edge that accepts the last sample.
REQ-028 HOLD: res_valid and res_data stay stable until res_valid & res_ready.
REQ-029 On the consuming edge, res_valid <= 0; next state is CLEAR if cont=1, else IDLE.
REQ-030 in_valid=1 while busy and state != RUN sets ovr; ovr holds until the next accepted start.
REQ-031 abort, in any state: next state IDLE, res_valid <= 0, cnt_up/cnt_down <= 0; abort has priority over every other transition.
REQ-032 start while busy SHALL be ignored.
REQ-033 The window counter never wraps; it is compared against WINDOW-1 at the point of acceptance.

Reset
REQ-034 With reset=0 at a rising edge: state = IDLE, window counter = 0.
REQ-035 Output reset values: cnt_up = 0, cnt_down = 0, res_valid = 0, res_data = 0, ovr = 0.
REQ-036 Reset SHALL take effect from any state, including mid-window and during HOLD.
REQ-037 While reset=0, cnt_rst_n = 0, so the external counter clears on the same edge.

Structure
REQ-038 Shared package window_ctrl_pkg: state enumeration, default WIDTH/WINDOW/WIN_W constants.
REQ-039 One sub-module, sample_window_timer: window counter with clear, increment enable and a terminal-count flag.
REQ-040 The up/down counter itself stays outside this block; the bench instantiates it alongside.

Verification (WINDOW = 8, WIDTH = 19)
REQ-041 start, then 8 back-to-back samples with in_bit=1 -> res_data = 8; res_valid high 2 edges after the 8th accept.
REQ-042 5 ones then 3 zeros -> res_data = 2; 8 zeros -> res_data = 0x7FFF8 (-8).
REQ-043 res_ready held low 10 cycles with in_valid pulses -> res_data and res_valid stable, ovr = 1.
REQ-044 cont=1 at consume -> cnt_rst_n low exactly 1 cycle; 2nd window result is independent of the 1st.
REQ-045 abort after 3 samples -> IDLE next edge, busy = 0, no res_valid; a following window of 8 ones -> 8.
REQ-046 reset=0 during HOLD -> all outputs at reset values after that edge; start during RUN -> no effect.
